// File: rtl/mem_stage_hs_if.sv
// Data-memory port of the MEM stage: valid/ready request channel plus a response channel.
// The master holds a request stable until it is accepted. The response is only valid/err/rdata.
interface mem_stage_hs_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic              rsp_valid;
  logic              rsp_err;
  logic [31:0]       rdata;

  modport master (
    output req_valid, addr, we, be, wdata,
    input  req_ready, rsp_valid, rsp_err, rdata
  );

  modport slave (
    input  req_valid, addr, we, be, wdata,
    output req_ready, rsp_valid, rsp_err, rdata
  );
endinterface

// File: rtl/mem_stage_hs.sv
// RV32I MEM stage with a variable-latency memory port, alignment checks and bus/timeout faults.
// Non-memory ops reach MEM/WB in 1 cycle; accesses hold the pipe via mem_stall_o; stall_i parks a finished result in DONE.
module mem_stage_hs #(
  parameter int ADDR_W           = 32,
  parameter int TIMEOUT_CYCLES   = 256,
  parameter bit CHECK_LOAD_ALIGN = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic [31:0]           alu_result_i,
  input  logic [31:0]           store_data_i,
  input  logic                  memread_i,
  input  logic                  memwrite_i,
  input  logic [2:0]            width_select_i,
  input  logic                  regwrite_i,
  input  logic [4:0]            rd_addr_i,
  input  logic [1:0]            wb_sel_i,
  input  logic [31:0]           pc_address_i,
  input  logic                  ex_valid_i,
  output logic                  mem_stall_o,
  mem_stage_hs_if.master        dmem,
  output logic [31:0]           mem_data_o,
  output logic [31:0]           alu_result_o,
  output logic [31:0]           pc_address_o,
  output logic                  regwrite_o,
  output logic [4:0]            rd_addr_o,
  output logic [1:0]            wb_sel_o,
  output logic                  mem_valid_o,
  output logic                  exc_valid_o,
  output logic [3:0]            exc_cause_o,
  output logic [31:0]           exc_addr_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  typedef struct packed {
    logic [31:0] mem_data;
    logic [31:0] alu_result;
    logic [31:0] pc;
    logic        regwrite;
    logic [4:0]  rd;
    logic [1:0]  wb_sel;
    logic        valid;
    logic        exc_valid;
    logic [3:0]  exc_cause;
    logic [31:0] exc_addr;
  } wb_t;

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  wb_t               wb_q, wb_d, res_q, pass_wb, rsp_wb;
  logic              wb_load, capture, res_latch;

  logic [31:0]       h_alu, h_pc;
  logic              h_store, h_regwrite, killed_q;
  logic [2:0]        h_width;
  logic [4:0]        h_rd;
  logic [1:0]        h_wb_sel;
  logic [ADDR_W-1:0] req_addr_q;
  logic [3:0]        req_be_q;
  logic [31:0]       req_wdata_q;
  logic              req_we_q;
  logic [CNT_W-1:0]  tmo_cnt_q;

  logic        mem_op, legal, misaligned, access, mis_exc;
  logic        rsp_done, tmo_hit, complete, fault;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, load_val;
  logic [7:0]  rsp_byte;
  logic [15:0] rsp_half;

  // EX-side decode: legality, alignment and the request lanes to register
  always_comb begin
    mem_op = memread_i | memwrite_i;
    if (memwrite_i) legal = width_select_i inside {3'b000, 3'b001, 3'b010};
    else            legal = width_select_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    misaligned = ((width_select_i[1:0] == 2'b01) & alu_result_i[0]) |
                 ((width_select_i[1:0] == 2'b10) & (alu_result_i[1:0] != 2'b00));
    misaligned = misaligned & (memwrite_i | CHECK_LOAD_ALIGN);
    access  = ex_valid_i & mem_op & legal & ~misaligned;
    mis_exc = ex_valid_i & mem_op & legal & misaligned;
    unique case (width_select_i[1:0])
      2'b00: begin
        be_d    = 4'b0001 << alu_result_i[1:0];
        wdata_d = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        be_d    = alu_result_i[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{store_data_i[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = store_data_i;
      end
    endcase
  end

  always_comb begin
    pass_wb            = '0;
    pass_wb.alu_result = alu_result_i;
    pass_wb.pc         = pc_address_i;
    pass_wb.regwrite   = regwrite_i & ~mis_exc;
    pass_wb.rd         = rd_addr_i;
    pass_wb.wb_sel     = wb_sel_i;
    pass_wb.valid      = ex_valid_i;
    pass_wb.exc_valid  = mis_exc;
    pass_wb.exc_cause  = mis_exc ? (memwrite_i ? 4'd6 : 4'd4) : 4'd0;
    pass_wb.exc_addr   = mis_exc ? alu_result_i : 32'd0;
  end

  // Completion: a response in WAIT, or the timeout expiring in REQ/WAIT
  always_comb begin
    rsp_done = (state_q == WAIT) & dmem.rsp_valid;
    tmo_hit  = (TIMEOUT_CYCLES != 0) && ((state_q == REQ) || (state_q == WAIT)) &&
               (tmo_cnt_q == TMO_LAST) && !rsp_done;
    complete = rsp_done | tmo_hit;
    fault    = (rsp_done & dmem.rsp_err) | tmo_hit;
  end

  always_comb begin
    rsp_byte = dmem.rdata[{h_alu[1:0], 3'b000} +: 8];
    rsp_half = h_alu[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
    unique case (h_width)
      3'b000:  load_val = {{24{rsp_byte[7]}}, rsp_byte};
      3'b001:  load_val = {{16{rsp_half[15]}}, rsp_half};
      3'b100:  load_val = {24'd0, rsp_byte};
      3'b101:  load_val = {16'd0, rsp_half};
      default: load_val = dmem.rdata;
    endcase
    rsp_wb            = '0;
    rsp_wb.mem_data   = (h_store | fault) ? 32'd0 : load_val;
    rsp_wb.alu_result = h_alu;
    rsp_wb.pc         = h_pc;
    rsp_wb.regwrite   = h_regwrite & ~fault;
    rsp_wb.rd         = h_rd;
    rsp_wb.wb_sel     = h_wb_sel;
    rsp_wb.valid      = 1'b1;
    rsp_wb.exc_valid  = fault;
    rsp_wb.exc_cause  = fault ? (h_store ? 4'd7 : 4'd5) : 4'd0;
    rsp_wb.exc_addr   = fault ? h_alu : 32'd0;
  end

  function automatic wb_t kill_fix(input wb_t w, input logic k);
    kill_fix = w;
    if (k) begin
      kill_fix.valid     = 1'b0;
      kill_fix.regwrite  = 1'b0;
      kill_fix.exc_valid = 1'b0;
      kill_fix.exc_cause = 4'd0;
      kill_fix.exc_addr  = 32'd0;
    end
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    mem_stall_o = 1'b0;
    wb_load     = 1'b0;
    wb_d        = wb_q;
    capture     = 1'b0;
    res_latch   = 1'b0;
    unique case (state_q)
      IDLE: begin
        mem_stall_o = access;
        if (flush_i) begin
          wb_load = 1'b1;
          wb_d    = '0;
        end else if (!stall_i) begin
          wb_load = 1'b1;
          if (access) begin
            capture = 1'b1;
            wb_d    = '0;
            state_d = REQ;
          end else begin
            wb_d = pass_wb;
          end
        end
      end
      REQ, WAIT: begin
        // Release EX in the completing cycle so the finished op is not re-issued
        mem_stall_o = ~complete;
        if ((state_q == REQ) && dmem.req_ready) state_d = WAIT;
        if (complete) begin
          if (!stall_i) begin
            wb_load = 1'b1;
            wb_d    = kill_fix(rsp_wb, killed_q | flush_i);
            state_d = IDLE;
          end else begin
            res_latch = 1'b1;
            state_d   = DONE;
          end
        end
      end
      DONE: begin
        mem_stall_o = stall_i;
        if (!stall_i) begin
          wb_load = 1'b1;
          wb_d    = kill_fix(res_q, killed_q | flush_i);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_q        <= '0;
      res_q       <= '0;
      h_alu       <= '0;
      h_pc        <= '0;
      h_store     <= 1'b0;
      h_width     <= '0;
      h_regwrite  <= 1'b0;
      h_rd        <= '0;
      h_wb_sel    <= '0;
      killed_q    <= 1'b0;
      req_addr_q  <= '0;
      req_be_q    <= '0;
      req_wdata_q <= '0;
      req_we_q    <= 1'b0;
      tmo_cnt_q   <= '0;
    end else begin
      if (wb_load)   wb_q  <= wb_d;
      if (res_latch) res_q <= rsp_wb;
      if (capture) begin
        h_alu       <= alu_result_i;
        h_pc        <= pc_address_i;
        h_store     <= memwrite_i;
        h_width     <= width_select_i;
        h_regwrite  <= regwrite_i;
        h_rd        <= rd_addr_i;
        h_wb_sel    <= wb_sel_i;
        killed_q    <= 1'b0;
        req_addr_q  <= {alu_result_i[ADDR_W-1:2], 2'b00};
        req_be_q    <= be_d;
        req_wdata_q <= wdata_d;
        req_we_q    <= memwrite_i;
      end else if ((state_q != IDLE) && flush_i) begin
        killed_q <= 1'b1;
      end
      tmo_cnt_q <= ((state_q == REQ) || (state_q == WAIT)) ? tmo_cnt_q + 1'b1 : '0;
    end
  end

  assign dmem.req_valid = (state_q == REQ);
  assign dmem.addr      = req_addr_q;
  assign dmem.we        = req_we_q;
  assign dmem.be        = req_be_q;
  assign dmem.wdata     = req_wdata_q;

  assign mem_data_o   = wb_q.mem_data;
  assign alu_result_o = wb_q.alu_result;
  assign pc_address_o = wb_q.pc;
  assign regwrite_o   = wb_q.regwrite;
  assign rd_addr_o    = wb_q.rd;
  assign wb_sel_o     = wb_q.wb_sel;
  assign mem_valid_o  = wb_q.valid;
  assign exc_valid_o  = wb_q.exc_valid;
  assign exc_cause_o  = wb_q.exc_cause;
  assign exc_addr_o   = wb_q.exc_addr;

endmodule
